// File: rtl/led_pio_arb_pkg.sv
// Shared definitions for the LED PIO arbiter.
// Includes the FSM state type, the PIO register address, the LED word width
// and the masked-merge helper.
package led_pio_arb_pkg;

    localparam int         LED_W         = 32;
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    // Replace only the bits selected by mask. All other bits keep their old value.
    function automatic logic [LED_W-1:0] merge_led(
        input logic [LED_W-1:0] old_val,
        input logic [LED_W-1:0] new_val,
        input logic [LED_W-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/led_pio_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin picker.
// The search starts one position after ptr (mod NREQ) and wraps around.
// It returns a one-hot grant, the winner's index, and an any-request flag.
// Other shared-PIO controllers reuse this module.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);

    // Scan from ptr+1 around the ring and keep the first requester found.
    always_comb begin : p_search
        int cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = PW'(cand);
            end else begin
                // an earlier candidate already won, or this one is idle
            end
        end
    end

endmodule

// File: rtl/led_pio_arbiter.sv
// led_pio_arbiter: shares one write-only 32-bit LED PIO between NREQ requesters.
// The block keeps a shadow of the LED word. Each granted request is merged into
// the shadow under its mask, and the new value is written in a one-cycle strobe.
// The build option LED_PIO_ARB_HEARTBEAT_EN adds an internal, lowest-priority
// heartbeat requester. It toggles bit HB_BIT every HB_DIV clock cycles.
module led_pio_arbiter
    import led_pio_arb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int HB_BIT = 31,
    parameter int HB_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [LED_W*NREQ-1:0] req_data,
    input  logic [LED_W*NREQ-1:0] req_mask,
    output logic [NREQ-1:0]       req_ack,
    output logic [1:0]            address,
    output logic                  chipselect,
    output logic                  write_n,
    output logic [LED_W-1:0]      writedata,
    output logic [LED_W-1:0]      led_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 1 || NREQ > 8 || HB_BIT < 0 || HB_BIT >= LED_W || HB_DIV < 2) begin : g_param_check
        $error("led_pio_arbiter: parameter out of range");
    end

    state_e             state_q, state_d;
    logic [LED_W-1:0]   shadow_q, shadow_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               cs_q, cs_d;
    logic               wn_q, wn_d;
    logic [LED_W-1:0]   wd_q, wd_d;
    logic [NREQ-1:0]    ack_q, ack_d;

    logic [NREQ-1:0]    arb_grant_s;
    logic [PW-1:0]      arb_idx_s;
    logic               arb_any_s;
    logic [LED_W-1:0]   data_g_s;
    logic [LED_W-1:0]   mask_g_s;

`ifdef LED_PIO_ARB_HEARTBEAT_EN
    localparam int               HBW       = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam logic [LED_W-1:0] HB_ONEHOT = 32'h0000_0001 << HB_BIT;
    // The heartbeat owns its bit, so external requesters can never change it.
    localparam logic [LED_W-1:0] EXT_MASK  = ~HB_ONEHOT;

    logic [HBW-1:0] hb_cnt_q, hb_cnt_d;
    logic           hb_pend_q, hb_pend_d;
    logic           hb_wrap_s;
    logic           hb_grant_s;

    // Free-running divider. On wrap it raises the pending flag, and a grant clears it.
    always_comb begin
        hb_wrap_s = (hb_cnt_q == HBW'(HB_DIV - 1));
        if (hb_wrap_s) begin
            hb_cnt_d = '0;
        end else begin
            hb_cnt_d = hb_cnt_q + HBW'(1);
        end
        hb_pend_d = (hb_pend_q & ~hb_grant_s) | hb_wrap_s;
    end

    // Heartbeat counter and pending-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_cnt_q  <= '0;
            hb_pend_q <= 1'b0;
        end else begin
            hb_cnt_q  <= hb_cnt_d;
            hb_pend_q <= hb_pend_d;
        end
    end
`else
    localparam logic [LED_W-1:0] EXT_MASK = {LED_W{1'b1}};
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .any   (arb_any_s)
    );

    // Select the winner's data and mask with an AND-OR mux on the one-hot grant.
    always_comb begin
        data_g_s = '0;
        mask_g_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            data_g_s = data_g_s | (req_data[LED_W*i +: LED_W] & {LED_W{arb_grant_s[i]}});
            mask_g_s = mask_g_s | (req_mask[LED_W*i +: LED_W] & {LED_W{arb_grant_s[i]}});
        end
        mask_g_s = mask_g_s & EXT_MASK;
    end

    // FSM next state: grant in IDLE, then one strobe cycle in WRITE.
    // The output registers are loaded on the grant edge, so the strobe, the ack
    // and the merged data all appear in the WRITE cycle. The registered one-hot
    // ack is the latched grant index.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        rr_ptr_d = rr_ptr_q;
        cs_d     = 1'b0;
        wn_d     = 1'b1;
        ack_d    = '0;
`ifdef LED_PIO_ARB_HEARTBEAT_EN
        hb_grant_s = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (arb_any_s) begin
                    shadow_d = merge_led(shadow_q, data_g_s, mask_g_s);
                    rr_ptr_d = arb_idx_s;
                    ack_d    = arb_grant_s;
                    cs_d     = 1'b1;
                    wn_d     = 1'b0;
                    state_d  = WRITE;
`ifdef LED_PIO_ARB_HEARTBEAT_EN
                end else if (hb_pend_q) begin
                    shadow_d   = shadow_q ^ HB_ONEHOT;
                    hb_grant_s = 1'b1;
                    cs_d       = 1'b1;
                    wn_d       = 1'b0;
                    state_d    = WRITE;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        wd_d = shadow_d;
    end

    // FSM state, shadow, round-robin pointer and registered PIO outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            rr_ptr_q <= PW'(NREQ - 1);
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            wd_q     <= '0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            rr_ptr_q <= rr_ptr_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            wd_q     <= wd_d;
            ack_q    <= ack_d;
        end
    end

    assign address    = PIO_ADDR_DATA;
    assign chipselect = cs_q;
    assign write_n    = wn_q;
    assign writedata  = wd_q;
    assign req_ack    = ack_q;
    assign led_state  = shadow_q;

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Self-checking bench for led_pio_arbiter (NREQ=3).
// A transaction-level model tracks the expected LED word, the last external
// winner and the heartbeat schedule. Directed steps are followed by a random phase.
module tb_led_pio_arbiter;

    localparam int N      = 3;
    localparam int HB_BIT = 31;
    localparam int HB_DIV = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_data;
    logic [32*N-1:0] req_mask;
    logic [N-1:0]    req_ack;
    logic [1:0]      address;
    logic            chipselect;
    logic            write_n;
    logic [31:0]     writedata;
    logic [31:0]     led_state;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_shadow;
    int          m_last;
    bit          m_wr;
    logic [N-1:0] m_ack;
    int          m_cnt;
    bit          m_pend;

    always #5 clk = ~clk;

    led_pio_arbiter #(
        .NREQ   (N),
        .HB_BIT (HB_BIT),
        .HB_DIV (HB_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_mask   (req_mask),
        .req_ack    (req_ack),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .led_state  (led_state)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow = 32'h0;
        m_last   = N - 1;
        m_wr     = 1'b0;
        m_ack    = '0;
        m_cnt    = 0;
        m_pend   = 1'b0;
    endtask

    // One rising edge: a write occupies this edge and the next. Otherwise the
    // first valid after the last winner wins, else the heartbeat if pending.
    task automatic model_edge();
        int          win;
        bit          wrap;
        logic [31:0] md;
        logic [31:0] mm;
        win  = -1;
        wrap = 1'b0;
`ifdef LED_PIO_ARB_HEARTBEAT_EN
        wrap  = (m_cnt == HB_DIV - 1);
        m_cnt = wrap ? 0 : m_cnt + 1;
`endif
        if (m_wr) begin
            m_wr  = 1'b0;
            m_ack = '0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (win < 0 && req_valid[i]) win = i;
            end
            if (win >= 0) begin
                md = req_data[32*win +: 32];
                mm = req_mask[32*win +: 32];
`ifdef LED_PIO_ARB_HEARTBEAT_EN
                mm[HB_BIT] = 1'b0;
`endif
                m_shadow = (m_shadow & ~mm) | (md & mm);
                m_last   = win;
                m_ack    = N'(1) << win;
                m_wr     = 1'b1;
            end else if (m_pend) begin
                m_shadow[HB_BIT] = ~m_shadow[HB_BIT];
                m_pend = 1'b0;
                m_ack  = '0;
                m_wr   = 1'b1;
            end
        end
        if (wrap) m_pend = 1'b1;
    endtask

    task automatic cmp_all();
        check32("chipselect", 32'(chipselect), 32'(m_wr));
        check32("write_n", 32'(write_n), 32'(!m_wr));
        check32("writedata", writedata, m_shadow);
        check32("led_state", led_state, m_shadow);
        check32("req_ack", 32'(req_ack), 32'(m_ack));
        check32("address", 32'(address), 32'h0);
    endtask

    // advance one clock: update the model on the rising edge, compare on the falling edge
    task automatic cyc();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [31:0] m);
        req_data[32*i +: 32] = d;
        req_mask[32*i +: 32] = m;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        bit seen;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_mask  = '0;
        model_reset();
        repeat (2) cyc();
        check32("rst_wn", 32'(write_n), 32'h1);
        check32("rst_led", led_state, 32'h0);
        reset = 1'b0;

        // single request: mask limits the update to the low nibble
        set_req(0, 32'h0000_00FF, 32'h0000_000F);
        req_valid = 3'b001;
        cyc();
        check32("t1_cs", 32'(chipselect), 32'h1);
        check32("t1_wd", writedata & 32'h7FFF_FFFF, 32'h0000_000F);
        check32("t1_ack", 32'(req_ack), 32'h1);
        req_valid = 3'b000;
        cyc();
        check32("t1_led", led_state & 32'h7FFF_FFFF, 32'h0000_000F);

        // second requester merges into an untouched region
        set_req(1, 32'hFFFF_FFFF, 32'h00F0_0000);
        req_valid = 3'b010;
        cyc();
        check32("t2_wd", writedata & 32'h7FFF_FFFF, 32'h00F0_000F);
        check32("t2_ack", 32'(req_ack), 32'h2);
        req_valid = 3'b000;
        cyc();

        // all valids held: strict rotation, one strobe every second cycle
        reset_pulse();
        set_req(0, 32'h0000_0011, 32'h0000_00FF);
        set_req(1, 32'h0000_2200, 32'h0000_FF00);
        set_req(2, 32'h0033_0000, 32'h00FF_0000);
        req_valid = 3'b111;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (c % 2 == 0) begin
                check32("rot_cs", 32'(chipselect), 32'h1);
                check32("rot_ack", 32'(req_ack), 32'h1 << ((c / 2) % 3));
            end else begin
                check32("rot_idle_cs", 32'(chipselect), 32'h0);
            end
        end
        req_valid = 3'b000;
        cyc();

        // a request raised during another's WRITE waits for the next IDLE
        req_valid = 3'b001;
        cyc();
        check32("late_ack0", 32'(req_ack), 32'h1);
        req_valid = 3'b100;
        cyc();
        check32("late_gap_cs", 32'(chipselect), 32'h0);
        cyc();
        check32("late_ack2", 32'(req_ack), 32'h4);
        check32("late_cs2", 32'(chipselect), 32'h1);
        req_valid = 3'b000;
        cyc();

        // reset in the middle of a WRITE aborts the strobe without a clock edge
        set_req(0, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        req_valid = 3'b001;
        cyc();
        check32("mid_cs_before", 32'(chipselect), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check32("mid_cs", 32'(chipselect), 32'h0);
        check32("mid_wn", 32'(write_n), 32'h1);
        check32("mid_ack", 32'(req_ack), 32'h0);
        req_valid = 3'b000;
        cyc();
        reset = 1'b0;
        cyc();
        check32("mid_led", led_state, 32'h0);

`ifdef LED_PIO_ARB_HEARTBEAT_EN
        // heartbeat alone: bit 31 set on the first wrap, cleared on the next
        reset_pulse();
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            cyc();
            seen = chipselect;
        end
        check32("hb1_seen", 32'(seen), 32'h1);
        check32("hb1_wd", writedata, 32'h8000_0000);
        check32("hb1_ack", 32'(req_ack), 32'h0);
        cyc();
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            cyc();
            seen = chipselect;
        end
        check32("hb2_seen", 32'(seen), 32'h1);
        check32("hb2_wd", writedata, 32'h0000_0000);
        cyc();
        set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 3'b001;
        cyc();
        check32("hb_mask_wd", writedata, 32'h7FFF_FFFF);
        req_valid = 3'b000;
        cyc();
`else
        seen = 1'b0;
        check32("no_hb_seen", 32'(seen), 32'(chipselect));
`endif

        // random traffic: hold each request until its ack, then drop it
        for (int c = 0; c < 400; c++) begin
            cyc();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && m_ack[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, $urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
                    req_valid[i] = 1'b1;
                end
            end
        end
        req_valid = 3'b000;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
